// File: rtl/kmem_wmem_loader.sv
// Learn-phase loader: streams kernel words into KMEM port 1, then W1/W2 pairs into WMEM port 1.
// Memory strobes, addresses and data are registered; only in_ready is a state decode.
module kmem_wmem_loader #(
  parameter int NUM_ADDR = 5,
  parameter int K_WORDS  = 2,
  parameter int W_WORDS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  output logic                busy,
  output logic                done,
  output logic [NUM_ADDR-1:0] KMEM_ADD1,
  output logic [31:0]         KR_DATA_I1,
  output logic                KMEM_CSB1,
  output logic                KMEM_WEB1,
  output logic                KMEM_OEB1,
  output logic [NUM_ADDR-1:0] WMEM_ADD1,
  output logic [31:0]         W1_DATA_I1,
  output logic [31:0]         W2_DATA_I1,
  output logic                WMEM_CSB1,
  output logic                WMEM_WEB1,
  output logic                WMEM_OEB1
);

  // state     | meaning
  // S_IDLE    | waiting for learn, counters cleared
  // S_LOAD_K  | accepting kernel words, one KMEM write per word
  // S_LOAD_W1 | capturing first word of a weight pair
  // S_LOAD_W2 | second word of the pair, one WMEM write per pair
  // S_DONE    | one-cycle done pulse, learn ignored
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_K  = 3'd1;
  localparam logic [2:0] S_LOAD_W1 = 3'd2;
  localparam logic [2:0] S_LOAD_W2 = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // One extra counter bit lets a full 2^NUM_ADDR load finish without wrapping.
  localparam int CW = NUM_ADDR + 1;
  localparam logic [CW-1:0] K_LAST = CW'(K_WORDS - 1);
  localparam logic [CW-1:0] W_LAST = CW'(W_WORDS - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] kcnt;
  logic [CW-1:0] wcnt;
  logic [31:0]   hold;
  logic          accept;

  assign in_ready  = (state == S_LOAD_K) || (state == S_LOAD_W1) || (state == S_LOAD_W2);
  assign accept    = in_valid && in_ready;
  assign KMEM_OEB1 = 1'b1;
  assign WMEM_OEB1 = 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (learn) state_nxt = S_LOAD_K;
      S_LOAD_K:  if (accept && (kcnt == K_LAST)) state_nxt = S_LOAD_W1;
      S_LOAD_W1: if (accept) state_nxt = S_LOAD_W2;
      S_LOAD_W2: if (accept) state_nxt = (wcnt == W_LAST) ? S_DONE : S_LOAD_W1;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      kcnt       <= '0;
      wcnt       <= '0;
      hold       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      KMEM_ADD1  <= '0;
      KR_DATA_I1 <= '0;
      KMEM_CSB1  <= 1'b1;
      KMEM_WEB1  <= 1'b1;
      WMEM_ADD1  <= '0;
      W1_DATA_I1 <= '0;
      W2_DATA_I1 <= '0;
      WMEM_CSB1  <= 1'b1;
      WMEM_WEB1  <= 1'b1;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      // Strobes fall back high on any edge without a qualifying accept.
      KMEM_CSB1 <= 1'b1;
      KMEM_WEB1 <= 1'b1;
      WMEM_CSB1 <= 1'b1;
      WMEM_WEB1 <= 1'b1;
      case (state)
        S_IDLE: begin
          kcnt <= '0;
          wcnt <= '0;
        end
        S_LOAD_K: begin
          if (accept) begin
            KMEM_CSB1  <= 1'b0;
            KMEM_WEB1  <= 1'b0;
            KMEM_ADD1  <= kcnt[NUM_ADDR-1:0];
            KR_DATA_I1 <= in_data;
            kcnt       <= kcnt + CW'(1);
          end
        end
        S_LOAD_W1: begin
          if (accept) hold <= in_data;
        end
        S_LOAD_W2: begin
          if (accept) begin
            WMEM_CSB1  <= 1'b0;
            WMEM_WEB1  <= 1'b0;
            WMEM_ADD1  <= wcnt[NUM_ADDR-1:0];
            W1_DATA_I1 <= hold;
            W2_DATA_I1 <= in_data;
            wcnt       <= wcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
